// File: rtl/dmem_serial_shim_if.sv
// Core/RAM bus bundle for dmem_serial_shim. The sext signal exists only when
// DMEM_SHIM_SEXT_EN is defined.
interface dmem_serial_shim_if #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
);
  logic                    req;
  logic                    we;
  logic [ADDR_W-1:0]       addr;
  logic [1:0]              size;
`ifdef DMEM_SHIM_SEXT_EN
  logic                    sext;
`endif
  logic [8*WORD_BYTES-1:0] wdata;
  logic [7:0]              ram_rdata;
  logic                    ram_ready;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [7:0]              ram_wdata;
  logic                    busy;
  logic                    done;
  logic [8*WORD_BYTES-1:0] rdata;

  // master: the core requester together with the byte RAM it talks through
  modport master (
    output req, we, addr, size, wdata, ram_rdata, ram_ready,
`ifdef DMEM_SHIM_SEXT_EN
    output sext,
`endif
    input  ram_en, ram_we, ram_addr, ram_wdata, busy, done, rdata
  );

  modport slave (
    input  req, we, addr, size, wdata, ram_rdata, ram_ready,
`ifdef DMEM_SHIM_SEXT_EN
    input  sext,
`endif
    output ram_en, ram_we, ram_addr, ram_wdata, busy, done, rdata
  );
endinterface

// File: rtl/dmem_serial_shim.sv
// Word-to-byte data-memory shim: serialises one load/store into little-endian
// byte beats with RAM wait states. Optional sign extension via DMEM_SHIM_SEXT_EN.
module dmem_serial_shim #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_serial_shim_if.slave bus
);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [WORD_BYTES-1:0][7:0] word_t;

  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        n_q, n_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] base_q, base_d;
  word_t             wdata_q, wdata_d;
  word_t             asm_q, asm_d;
  word_t             rdata_q, rdata_d;
  logic [3:0]        n_raw, n_req;
  logic              sext_in;
  logic              xfer;

`ifdef DMEM_SHIM_SEXT_EN
  assign sext_in = bus.sext;
`else
  assign sext_in = 1'b0;
`endif

  // Bytes at or above n are replaced by zero or by the sign of byte n-1.
  function automatic word_t extend_load(input word_t bytes, input logic [3:0] n,
                                        input logic sx);
    word_t             res;
    logic signed [7:0] top;
    logic              fill;
    top = '0;
    for (int b = 0; b < WORD_BYTES; b++)
      if (b == int'(n) - 1) top = $signed(bytes[b]);
    fill = sx & (top < 0);
    for (int b = 0; b < WORD_BYTES; b++)
      res[b] = (b < int'(n)) ? bytes[b] : {8{fill}};
    return res;
  endfunction

  assign n_raw = 4'd1 << bus.size;
  assign n_req = (n_raw > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : n_raw;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    we_d    = we_q;
    sext_d  = sext_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          base_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          n_d     = n_req;
          sext_d  = sext_in;
          idx_d   = 4'd0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.ram_ready) begin
          if (!we_q) asm_d[idx_q[IW-1:0]] = bus.ram_rdata;
          idx_d = idx_q + 4'd1;
          if (idx_q == n_q - 4'd1) begin
            state_d = DONE;
            // The final byte arrives on this edge, so extend the merged word.
            if (!we_q) rdata_d = extend_load(asm_d, n_q, sext_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      n_q     <= 4'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
    end
  end

  // Beat payload registers are only observed during XFER.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

  assign xfer          = (state_q == XFER);
  assign bus.ram_en    = xfer;
  assign bus.ram_we    = xfer & we_q;
  assign bus.ram_addr  = xfer ? (base_q + ADDR_W'(idx_q)) : '0;
  assign bus.ram_wdata = xfer ? wdata_q[idx_q[IW-1:0]] : 8'h00;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_serial_shim.sv
// Directed bench for dmem_serial_shim: a 4-byte and an 8-byte instance, with
// beat and load-result scoreboards.
module tb_dmem_serial_shim;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef DMEM_SHIM_SEXT_EN
  localparam bit SEXT_ON = 1'b1;
`else
  localparam bit SEXT_ON = 1'b0;
`endif

  dmem_serial_shim_if #(.ADDR_W(32), .WORD_BYTES(4)) b4 ();
  dmem_serial_shim_if #(.ADDR_W(32), .WORD_BYTES(8)) b8 ();

  dmem_serial_shim #(.ADDR_W(32), .WORD_BYTES(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  dmem_serial_shim #(.ADDR_W(32), .WORD_BYTES(8)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));

  int          n_err = 0;
  int          n_chk = 0;
  int          done4 = 0;
  int          done8 = 0;
  int          lows8 = 0;
  logic [7:0]  mem4 [16];
  logic        phase = 1'b0;
  logic        alt8  = 1'b0;
  logic [40:0] q4b[$];
  logic [40:0] q8b[$];
  logic [63:0] q4r[$];
  logic [63:0] q8r[$];
  logic [63:0] last4 = '0;
  logic [63:0] last8 = '0;

  assign b4.ram_rdata = mem4[b4.ram_addr[3:0]];
  assign b4.ram_ready = 1'b1;
  assign b8.ram_rdata = 8'h00;
  assign b8.ram_ready = alt8 ? phase : 1'b1;
  always @(posedge clk) phase <= ~phase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [31:0] a, input int n,
                                             input logic sx, input int wb);
    logic [63:0] v;
    int          sh;
    v = '0;
    for (int b = 0; b < n; b++) begin
      logic [31:0] ab;
      ab = a + 32'(b);
      v  = v | (64'(mem4[ab[3:0]]) << (8 * b));
    end
    sh = 64 - 8 * n;
    if (sx && n < wb) v = 64'($signed(v << sh) >>> sh);
    if (wb < 8) v = v & ((64'd1 << (8 * wb)) - 64'd1);
    return v;
  endfunction

  task automatic drive4(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic sx);
    b4.req = 1'b1; b4.we = w; b4.addr = a; b4.size = sz; b4.wdata = wd;
`ifdef DMEM_SHIM_SEXT_EN
    b4.sext = sx;
`endif
  endtask

  task automatic expect4(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic sx);
    int n;
    n = 1 << sz;
    if (n > 4) n = 4;
    for (int b = 0; b < n; b++) q4b.push_back({w, a + 32'(b), wd[8*b +: 8]});
    if (!w) last4 = model_load(a, n, sx & SEXT_ON, 4);
    q4r.push_back(last4);
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!b4.done && cyc < 60);
    if (!b4.done) chk("timeout4", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!b8.done && cyc < 80);
    if (!b8.done) chk("timeout8", 64'd0, 64'd1);
    #1;
  endtask

  // Scoreboard monitors: beats compared while held, popped when RAM is ready.
  always @(negedge clk) begin
    if (b4.ram_en) begin
      chk("busy4_in_xfer", 64'(b4.busy), 64'd1);
      if (q4b.size() == 0) chk("beat4_unexpected", 64'd1, 64'd0);
      else begin
        chk("beat4", 64'({b4.ram_we, b4.ram_addr, b4.ram_wdata}), 64'(q4b[0]));
        if (b4.ram_ready) void'(q4b.pop_front());
      end
    end
    if (b4.done) begin
      done4++;
      chk("done4_ram_en", 64'(b4.ram_en), 64'd0);
      if (q4r.size() == 0) chk("done4_unexpected", 64'd1, 64'd0);
      else chk("rdata4", 64'(b4.rdata), q4r.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b8.ram_en) begin
      if (!b8.ram_ready) lows8++;
      if (q8b.size() == 0) chk("beat8_unexpected", 64'd1, 64'd0);
      else begin
        chk("beat8", 64'({b8.ram_we, b8.ram_addr, b8.ram_wdata}), 64'(q8b[0]));
        if (b8.ram_ready) void'(q8b.pop_front());
      end
    end
    if (b8.done) begin
      done8++;
      chk("done8_ram_en", 64'(b8.ram_en), 64'd0);
      if (q8r.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
      else chk("rdata8", b8.rdata, q8r.pop_front());
    end
  end

  initial begin
    int c;
    int d0;
    reset = 1'b0;
    b4.req = 1'b0; b4.we = 1'b0; b4.addr = '0; b4.size = '0; b4.wdata = '0;
    b8.req = 1'b0; b8.we = 1'b0; b8.addr = '0; b8.size = '0; b8.wdata = '0;
`ifdef DMEM_SHIM_SEXT_EN
    b4.sext = 1'b0; b8.sext = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 64'(b4.ram_en), 64'd0);
    chk("rst_ram_we", 64'(b4.ram_we), 64'd0);
    chk("rst_ram_addr", 64'(b4.ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(b4.ram_wdata), 64'd0);
    chk("rst_busy", 64'(b4.busy), 64'd0);
    chk("rst_done", 64'(b4.done), 64'd0);
    chk("rst_rdata", 64'(b4.rdata), 64'd0);
    chk("rst_rdata8", b8.rdata, 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // 4-byte load
    mem4[0] = 8'h11; mem4[1] = 8'h22; mem4[2] = 8'h33; mem4[3] = 8'h44;
    drive4(1'b0, 32'h100, 2'd2, 32'h0, 1'b0); expect4(1'b0, 32'h100, 2'd2, 32'h0, 1'b0);
    @(posedge clk); #1 b4.req = 1'b0;
    wait_done4(c);
    chk("lat_4B", 64'(c), 64'd5);
    chk("rdata_4B_value", 64'(b4.rdata), 64'h44332211);
    chk("q4_drained_4B", 64'(q4b.size()), 64'd0);

    // Byte load with top bit set
    @(posedge clk); #1;
    mem4[5] = 8'h80;
    drive4(1'b0, 32'h105, 2'd0, 32'h0, 1'b1); expect4(1'b0, 32'h105, 2'd0, 32'h0, 1'b1);
    @(posedge clk); #1 b4.req = 1'b0;
    wait_done4(c);
    chk("lat_1B", 64'(c), 64'd2);
    chk("rdata_1B_value", 64'(b4.rdata), SEXT_ON ? 64'hFFFFFF80 : 64'h00000080);

    // size=3 on a 4-byte shim clamps to four beats
    @(posedge clk); #1;
    mem4[8] = 8'hA1; mem4[9] = 8'hB2; mem4[10] = 8'hC3; mem4[11] = 8'hD4;
    drive4(1'b0, 32'h108, 2'd3, 32'h0, 1'b0); expect4(1'b0, 32'h108, 2'd3, 32'h0, 1'b0);
    @(posedge clk); #1 b4.req = 1'b0;
    wait_done4(c);
    chk("lat_clamp", 64'(c), 64'd5);

    // Halfword load, negative
    @(posedge clk); #1;
    mem4[12] = 8'h01; mem4[13] = 8'hF0;
    drive4(1'b0, 32'h10C, 2'd1, 32'h0, 1'b1); expect4(1'b0, 32'h10C, 2'd1, 32'h0, 1'b1);
    @(posedge clk); #1 b4.req = 1'b0;
    wait_done4(c);
    chk("lat_2B", 64'(c), 64'd3);

    // Store with req held high and fields changed mid-access
    @(posedge clk); #1;
    d0 = done4;
    drive4(1'b1, 32'h200, 2'd2, 32'hA1B2C3D4, 1'b0); expect4(1'b1, 32'h200, 2'd2, 32'hA1B2C3D4, 1'b0);
    @(posedge clk); #1;
    drive4(1'b1, 32'h300, 2'd2, 32'h55667788, 1'b0); expect4(1'b1, 32'h300, 2'd2, 32'h55667788, 1'b0);
    wait_done4(c);
    chk("lat_store", 64'(c), 64'd5);
    chk("one_done_first", 64'(done4 - d0), 64'd1);
    @(negedge clk);
    chk("idle_gap_busy", 64'(b4.busy), 64'd0);
    @(negedge clk);
    chk("reaccept_busy", 64'(b4.busy), 64'd1);
    b4.req = 1'b0;
    wait_done4(c);
    chk("lat_reissue", 64'(c), 64'd4);
    chk("two_dones", 64'(done4 - d0), 64'd2);
    chk("q4_drained_st", 64'(q4b.size()), 64'd0);

    // Reset during beat 2 of a 4-byte load
    @(posedge clk); #1;
    d0 = done4;
    drive4(1'b0, 32'h100, 2'd2, 32'h0, 1'b0); expect4(1'b0, 32'h100, 2'd2, 32'h0, 1'b0);
    @(posedge clk); #1 b4.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("beat2_addr", 64'(b4.ram_addr), 64'h102);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ram_en", 64'(b4.ram_en), 64'd0);
    chk("mid_rst_ram_addr", 64'(b4.ram_addr), 64'd0);
    chk("mid_rst_ram_wdata", 64'(b4.ram_wdata), 64'd0);
    chk("mid_rst_busy", 64'(b4.busy), 64'd0);
    chk("mid_rst_done", 64'(b4.done), 64'd0);
    chk("mid_rst_rdata", 64'(b4.rdata), 64'd0);
    #1;
    chk("mid_rst_beat_left", 64'(q4b.size()), 64'd1);
    chk("mid_rst_no_done", 64'(done4 - d0), 64'd0);
    q4b.delete(); q4r.delete(); last4 = '0;
    @(posedge clk); #1 reset = 1'b1;

    // Address wrap across the top of the space
    @(posedge clk); #1;
    mem4[14] = 8'h5A; mem4[15] = 8'h6B; mem4[0] = 8'h7C; mem4[1] = 8'h8D;
    drive4(1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 1'b0); expect4(1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 1'b0);
    @(posedge clk); #1 b4.req = 1'b0;
    wait_done4(c);
    chk("lat_wrap", 64'(c), 64'd5);
    chk("rdata_wrap_value", 64'(b4.rdata), 64'h8D7C6B5A);

    // 8-byte store with ready low every other cycle
    @(posedge clk); #1;
    alt8 = 1'b1; lows8 = 0; d0 = done8;
    b8.req = 1'b1; b8.we = 1'b1; b8.addr = 32'h400; b8.size = 2'd3;
    b8.wdata = 64'h0807060504030201;
    for (int b = 0; b < 8; b++) q8b.push_back({1'b1, 32'h400 + 32'(b), 8'(b + 1)});
    q8r.push_back(last8);
    @(posedge clk); #1 b8.req = 1'b0;
    wait_done8(c);
    chk("waits_seen", 64'(lows8 != 0), 64'd1);
    chk("lat_8B_waits", 64'(c), 64'(9 + lows8));
    chk("one_done_8B", 64'(done8 - d0), 64'd1);
    chk("q8_drained", 64'(q8b.size()), 64'd0);
    alt8 = 1'b0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_serial_shim.md
# dmem_serial_shim

Parametrised data-memory shim between the Y86 core's memory stage and a byte-wide data RAM. Accepts one word-level load/store request, serialises it into 1–8 little-endian byte beats with RAM wait-state support, and returns the assembled load word with a one-cycle completion pulse. It generalises the fixed 4-byte shim with configurable address width, word size and per-access size, a RAM ready handshake, and optional sign extension.

## Interface
- `ADDR_W`, 32: byte-address width.
- `WORD_BYTES`, 4: maximum bytes per access. Legal values are 1, 2, 4 and 8; 8 serves Y86-64 quads.
- `clk` input, 1: clock. Every register updates on the rising edge.
- `reset` input, 1: synchronous, active-low reset.
- `req` input, 1: access request. Sampled only in IDLE.
- `we` input, 1: 1 = store, 0 = load.
- `addr` input, ADDR_W: base byte address.
- `size` input, 2: access size; 0=1B, 1=2B, 2=4B, 3=8B.
- `sext` input, 1: sign-extend a sub-word load. Present only with the macro.
- `wdata` input, 8*WORD_BYTES: store data; byte 0 is the LSB.
- `ram_rdata` input, 8: byte returned by the RAM; valid combinationally in the same cycle.
- `ram_ready` input, 1: RAM accepts/returns the current beat this cycle.
- `ram_en` output, 1: beat active.
- `ram_we` output, 1: beat is a write.
- `ram_addr` output, ADDR_W: beat byte address.
- `ram_wdata` output, 8: beat write byte.
- `busy` output, 1: state ≠ IDLE.
- `done` output, 1: one-cycle completion pulse.
- `rdata` output, 8*WORD_BYTES: load result.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - On `req`=1 at an edge, latch `addr`, `we`, `wdata`, byte count N and `sext`.
  - Clear beat index i to 0 and go to XFER.
  - N = 2^size, clamped to WORD_BYTES.
- XFER:
  - `ram_en`=1, `ram_we`=latched we, `ram_addr`=(base+i) mod 2^ADDR_W, `ram_wdata`=byte i of latched wdata.
  - Edge with `ram_ready`=1: for a load, capture `ram_rdata` into byte i of the assembly register. Then i increments. If i==N-1, go to DONE.
  - Edge with `ram_ready`=0: hold i and all beat outputs.
- DONE:
  - `done`=1 and `ram_en`=0.
  - For a load, `rdata` updates at the DONE edge: bytes ≥N are zero, or copies of bit 8N-1 if sign extension applies. Stores leave `rdata` unchanged.
  - Return to IDLE on the next edge.
- Outside XFER, `ram_en`, `ram_we`, `ram_addr` and `ram_wdata` are 0. Outputs are never tristated.
- `req` while `busy` is ignored, not queued. The requester re-asserts after `done`.
- Latched request fields do not follow input changes mid-access.

## Timing
- Reset (`reset`=0 at an edge):
  - State goes to IDLE and i to 0.
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `busy`, `done` and `rdata` all go to 0.
  - Reset takes precedence over every other event.
- Latency with `ram_ready` held at 1:
  - `req` sampled at edge E0.
  - Beats occupy cycles E0+1 through E0+N.
  - `done` is high in cycle E0+N+1.
  - IDLE at E0+N+2. The earliest next acceptance is that edge, so throughput is one access per N+2 cycles.
- Each low `ram_ready` cycle during XFER adds exactly one cycle.
- `busy` is high from E0+1 through the `done` cycle inclusive.
- `rdata` is valid from the `done` cycle and holds until the next load completes.
- Address wrap: base 0xFFFFFFFF with N=2 issues 0xFFFFFFFF then 0x00000000. No error is flagged.
- Reset mid-XFER: the beat is abandoned, `ram_en` is 0 in the next cycle, no `done` pulse, and `rdata` is 0.

## Configuration
- Macro: `DMEM_SHIM_SEXT_EN`.
- Defined:
  - The `sext` port exists and is latched with the request.
  - A load with N < WORD_BYTES and sext=1 fills upper bytes with bit 8N-1.
- Undefined:
  - No `sext` port.
  - All loads are zero-extended.
  - Port list and timing are otherwise identical.

## Test plan
- 4B read: WORD_BYTES=4, ram_ready=1, addr 0x100, RAM bytes 0x100..0x103 = 11,22,33,44. Expect addr 0x100–0x103 in four consecutive cycles, `done` at E0+5, `rdata`=0x44332211.
- 8B write with waits: WORD_BYTES=8, wdata 0x0807060504030201, ram_ready low every second cycle. Expect bytes 01..08 at addr..addr+7, each beat held while not ready, `done` after 8 ready beats, `rdata` unchanged.
- Sub-word load: size=0, RAM byte 0x80. Expect `rdata`=0x00000080. With macro and sext=1, expect 0xFFFFFF80. Also size=3 with WORD_BYTES=4: clamped to 4 beats.
- Busy collision: second `req` asserted during the XFER of a store. Expect it ignored, exactly one access and one `done`. Re-assert after `done` and expect acceptance at E0+N+2.
- Mid-op reset: reset=0 during beat 2 of a 4B read. Expect all outputs 0 the next cycle, no `done`, and a subsequent request that completes normally.
- Wrap: addr 0xFFFFFFFE, size=2, load. Expect ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
